instr_encoder_loader: RTL

Sequential program loader and instruction encoder, the writer side of the pipeline's instruction decoder. Accepts symbolic instruction descriptors over a valid/ready handshake and encodes each into the 32-bit MIPS-style word the decoder consumes. Writes the words sequentially into instruction memory from address 0. Used at bring-up and by benches to load programs before releasing the pipeline.

---
 rtl/instr_encoder_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes symbolic instruction descriptors into 32-bit MIPS-style words
// and writes them sequentially into instruction memory. Optional macro: BRANCH_NOP_EN.
module instr_encoder_loader #(
   parameter int ADDR_W    = 8,
   parameter int NOP_SLOTS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op_class,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [5:0]        funct,
   input  logic [15:0]       imm,
   input  logic              last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_data,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              error
);

`ifdef BRANCH_NOP_EN
   typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, PAD, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
`endif

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t      state, nxt;
   logic [31:0] word_q;
   logic        last_q;
   logic [31:0] enc_word;
   logic        enc_legal;
   logic        at_max;
   logic        take;
   logic        ovf_w;

`ifdef BRANCH_NOP_EN
   localparam logic [1:0] PAD_END = 2'(NOP_SLOTS - 1);
   logic       branch_q;
   logic [1:0] pad_cnt;
   logic       pad_last;
   logic       ovf_p;
   assign pad_last = (pad_cnt == PAD_END);
   // A branch landing in the last slot cannot fit its NOPs, so it overflows even with last set.
   assign ovf_w    = at_max && (!last_q || branch_q);
   assign ovf_p    = at_max && !(pad_last && last_q);
`else
   assign ovf_w    = at_max && !last_q;
`endif

   // Fields a class does not use stay zero no matter what the inputs carry.
   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (op_class)
         4'd0:    enc_word = '0;
         4'd1:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, funct};
         4'd2:    enc_word = {6'b001000, rs, rt, imm};
         4'd3:    enc_word = {6'b100011, rs, rt, imm};
         4'd4:    enc_word = {6'b101011, rs, rt, imm};
         4'd5:    enc_word = {6'b000100, rs, rt, imm};
         4'd6:    enc_word = {6'b000101, rs, rt, imm};
         4'd7:    enc_word = {6'b000001, rs, 5'b00000, imm};
         4'd8:    enc_word = {6'b000001, rs, 5'b00001, imm};
         4'd9:    enc_word = {6'b000110, rs, 5'b00000, imm};
         4'd10:   enc_word = {6'b000111, rs, 5'b00000, imm};
         default: enc_legal = 1'b0;
      endcase
   end

   assign at_max    = (imem_addr == ADDR_MAX);
   assign take      = (state == ACCEPT) && in_valid;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign imem_data = (state == WRITE) ? word_q : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt      = state;
      in_ready = 1'b0;
      imem_we  = 1'b0;
      case (state)
         IDLE:   if (start) nxt = ACCEPT;
         ACCEPT: begin
            in_ready = 1'b1;
            if (in_valid && enc_legal) nxt = WRITE;
         end
         WRITE: begin
            imem_we = 1'b1;
            if (at_max) nxt = DONE;
`ifdef BRANCH_NOP_EN
            else if (branch_q) nxt = PAD;
`endif
            else if (last_q) nxt = DONE;
            else nxt = ACCEPT;
         end
`ifdef BRANCH_NOP_EN
         PAD: begin
            imem_we = 1'b1;
            if (at_max) nxt = DONE;
            else if (pad_last) nxt = last_q ? DONE : ACCEPT;
         end
`endif
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q    <= '0;
         last_q    <= 1'b0;
         imem_addr <= '0;
         count     <= '0;
         error     <= 1'b0;
`ifdef BRANCH_NOP_EN
         branch_q  <= 1'b0;
         pad_cnt   <= '0;
`endif
      end else begin
         if (state == IDLE && start) begin
            imem_addr <= '0;
            count     <= '0;
            error     <= 1'b0;
         end
         if (take && !enc_legal) error <= 1'b1;
         if (take && enc_legal) begin
            word_q   <= enc_word;
            last_q   <= last;
`ifdef BRANCH_NOP_EN
            branch_q <= (op_class >= 4'd5) && (op_class <= 4'd10);
            pad_cnt  <= '0;
`endif
         end
         // The address saturates at the top of memory; count keeps tallying writes.
         if (imem_we) begin
            count <= count + 1'b1;
            if (!at_max) imem_addr <= imem_addr + 1'b1;
         end
         if (state == WRITE && ovf_w) error <= 1'b1;
`ifdef BRANCH_NOP_EN
         if (state == PAD) begin
            pad_cnt <= pad_cnt + 1'b1;
            if (ovf_p) error <= 1'b1;
         end
`endif
      end
   end

endmodule
